instr_mem_loader: RTL and testbench

- Writable 32 x 19-bit instruction store with a byte-stream load port.
- Host or debug link pushes program bytes over a valid/ready handshake. The block assembles each group of 3 bytes into one 19-bit instruction and writes it at consecutive addresses starting from 0.
- The CPU fetch side reads through a combinational address/instruction port, matching the existing instruction-fetch interface.
- `busy` is used by the core to stall fetch while a program download is in progress.

---
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 tb/tb_instr_mem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction store with a byte-stream download port. Every 3 accepted bytes form one
// instruction, written at consecutive addresses from 0. Fetch reads combinationally.
module instr_mem_loader #(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    input  logic [5:0]             load_count,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [5:0]             loaded_count,
    input  logic [ADDR_WIDTH-1:0]  address,
    output logic [INSTR_WIDTH-1:0] instruction
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int HI_BITS = INSTR_WIDTH - 16;
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [5:0]              count_reg;
    logic [5:0]              loaded_count_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [1:0]              byte_idx_reg;
    logic                    error_reg;
    logic [INSTR_WIDTH-1:0]  word_asm;
    logic [INSTR_WIDTH-1:0]  mem [DEPTH];

    logic       byte_accept;
    logic       last_word;
    logic       pad_bad;
    logic [5:0] sat_count;

    assign byte_accept = in_valid & in_ready;
    assign last_word   = (6'(loaded_count_reg + 6'd1) == count_reg);
    // Only the low HI_BITS of the third byte fit in the word; anything above is padding.
    assign pad_bad     = ((in_data >> HI_BITS) != 8'd0);
    assign sat_count   = ({1'b0, load_count} > DEPTH_C) ? DEPTH_C[5:0] : load_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_start) state_next = (sat_count == 6'd0) ? DONE : RECV;
            RECV:    if (byte_accept && byte_idx_reg == 2'd2) state_next = WRITE;
            WRITE:   state_next = last_word ? DONE : RECV;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_reg)
            RECV:    begin in_ready = 1'b1; busy = 1'b1; end
            WRITE:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // One lane register per byte position; the top lane is truncated to the word width.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            localparam int LW = (gi < 2) ? 8 : HI_BITS;
            logic [LW-1:0] lane_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (state_reg == RECV && byte_accept && byte_idx_reg == 2'(gi)) begin
                    lane_reg <= in_data[LW-1:0];
                end
            end
            assign word_asm[gi*8 +: LW] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg        <= '0;
            loaded_count_reg <= '0;
            wr_addr_reg      <= '0;
            byte_idx_reg     <= '0;
            error_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (load_start) begin
                    count_reg        <= sat_count;
                    loaded_count_reg <= '0;
                    wr_addr_reg      <= '0;
                    byte_idx_reg     <= '0;
                    error_reg        <= 1'b0;
                end
                RECV: if (byte_accept) begin
                    byte_idx_reg <= (byte_idx_reg == 2'd2) ? 2'd0 : byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd2 && pad_bad) error_reg <= 1'b1;
                end
                WRITE: begin
                    wr_addr_reg      <= wr_addr_reg + 1'b1;
                    loaded_count_reg <= loaded_count_reg + 6'd1;
                    byte_idx_reg     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared by reset; a reset landing on a WRITE edge drops that word.
    always_ff @(posedge clk) begin
        if (rst_n && state_reg == WRITE) begin
            mem[wr_addr_reg] <= word_asm;
        end
    end

    assign instruction  = mem[address];
    assign error        = error_reg;
    assign loaded_count = loaded_count_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: download, padding, back-pressure, saturation,
// zero-count, reset mid-load and read-during-write behaviour.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [5:0]  load_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  loaded_count;
    logic [4:0]  address;
    logic [18:0] instruction;

    int checks = 0;
    int errors = 0;

    instr_mem_loader #(.ADDR_WIDTH(5), .INSTR_WIDTH(19)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_count   (load_count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .loaded_count (loaded_count),
        .address      (address),
        .instruction  (instruction)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [18:0] exp);
        address = a;
        #1;
        check(tag, 32'(instruction), 32'(exp));
    endtask

    initial begin
        logic [7:0]  bytes1 [8];
        logic [7:0]  stream [96];
        logic [18:0] word4;
        int          k;
        int          done_pulses;
        int          cyc;

        rst_n = 1'b0; load_start = 1'b0; load_count = 6'd0;
        in_data = 8'd0; in_valid = 1'b0; address = 5'd0;
        step(); step();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_loaded_count", 32'(loaded_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic load: byte offered with load_start must not be consumed.
        bytes1 = '{8'h34, 8'h12, 8'h05, 8'hAA, 8'hFF, 8'hFF, 8'h07, 8'hBB};
        load_start = 1'b1; load_count = 6'd2; in_valid = 1'b1; in_data = 8'h34;
        step();
        load_start = 1'b0;
        check("basic_recv_ready", 32'(in_ready), 32'd1);
        check("basic_recv_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            in_data = bytes1[i];
            if (i == 3) check("basic_write_ready", 32'(in_ready), 32'd0);
            step();
            if (i < 7) check("basic_no_early_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_done", 32'(busy), 32'd0);
        check("basic_loaded_count", 32'(loaded_count), 32'd2);
        check("basic_error", 32'(error), 32'd0);
        step();
        check("basic_done_pulse_end", 32'(done), 32'd0);
        read_check("basic_mem0", 5'd0, 19'h51234);
        read_check("basic_mem1", 5'd1, 19'h7FFFF);

        // Padding error plus read-during-write on address 0.
        load_start = 1'b1; load_count = 6'd1;
        step();
        load_start = 1'b0; in_valid = 1'b1;
        in_data = 8'h00; step();
        in_data = 8'h00; step();
        in_data = 8'hF9; step();
        in_valid = 1'b0;
        read_check("rdw_old_value", 5'd0, 19'h51234);
        step();
        read_check("rdw_new_value", 5'd0, 19'h10000);
        check("pad_error_set", 32'(error), 32'd1);
        check("pad_loaded_count", 32'(loaded_count), 32'd1);
        step(); step(); step();
        check("pad_error_sticky", 32'(error), 32'd1);

        // Back-pressure/gaps with a load_start pulse inside RECV that must be ignored.
        load_start = 1'b1; load_count = 6'd1;
        step();
        check("bp_error_cleared", 32'(error), 32'd0);
        load_start = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; step();
        in_valid = 1'b0; in_data = 8'h55; step();
        in_valid = 1'b0; in_data = 8'h66; load_start = 1'b1; load_count = 6'd0; step();
        load_start = 1'b0;
        check("bp_ignore_start_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 8'hBB; step();
        in_valid = 1'b0; in_data = 8'h77; step();
        in_valid = 1'b1; in_data = 8'h03; step();
        in_data = 8'hEE;
        check("bp_write_ready", 32'(in_ready), 32'd0);
        step();
        check("bp_done_ready", 32'(in_ready), 32'd0);
        check("bp_done", 32'(done), 32'd1);
        in_valid = 1'b0;
        step();
        read_check("bp_mem0", 5'd0, 19'h3BBAA);

        // Saturating count: 40 requested, 32 written.
        for (int w = 0; w < 32; w++) begin
            stream[3*w]     = 8'(w);
            stream[3*w + 1] = 8'(w) ^ 8'hA5;
            stream[3*w + 2] = 8'(w & 7);
        end
        load_start = 1'b1; load_count = 6'd40;
        step();
        load_start = 1'b0;
        k = 0; done_pulses = 0; cyc = 0;
        while (cyc < 160 && !(done_pulses > 0 && done == 1'b0)) begin
            logic rdy;
            in_valid = (k < 96);
            in_data  = (k < 96) ? stream[k] : 8'h00;
            rdy = in_ready;
            step();
            if (rdy && k < 96) k++;
            if (done) done_pulses++;
            cyc++;
        end
        in_valid = 1'b0;
        check("sat_bytes_consumed", 32'(k), 32'd96);
        check("sat_done_pulses", 32'(done_pulses), 32'd1);
        check("sat_loaded_count", 32'(loaded_count), 32'd32);
        check("sat_cycles", 32'(cyc), 32'd129);
        for (int w = 0; w < 32; w++) begin
            word4 = {3'(w & 7), 8'(w) ^ 8'hA5, 8'(w)};
            read_check($sformatf("sat_mem%0d", w), 5'(w), word4);
        end

        // Zero count: done next cycle, memory untouched.
        load_start = 1'b1; load_count = 6'd0;
        step();
        load_start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_loaded_count", 32'(loaded_count), 32'd0);
        read_check("zero_mem0", 5'd0, 19'h0A500);
        step();
        check("zero_done_end", 32'(done), 32'd0);

        // Reset after 4 bytes of a 3-word load.
        load_start = 1'b1; load_count = 6'd3;
        step();
        load_start = 1'b0; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h01; step();
        step();
        in_data = 8'h33; step();
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_loaded_count", 32'(loaded_count), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_no_done_after", 32'(done), 32'd0);
        check("rst_idle_ready", 32'(in_ready), 32'd0);
        read_check("rst_mem0", 5'd0, 19'h12211);
        read_check("rst_mem1", 5'd1, 19'h1A401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
